// File: rtl/smvm_issue_if.sv
// smvm_issue_if: element stream, issue group and result side-band bundle for
// the SMVM issue controller.
//   master : stream/command source (start, rows, in_*), sees ready, issue, res, status
//   slave  : the controller side (drives in_ready, issue_*, res_*, busy, done)
// Lane l of every K-wide field sits at the MSB end for l=0
// (val/col bits [8*(K-l)-1 -: 8], mask/ipv bit K-1-l).
interface smvm_issue_if #(parameter int K = 4);
  logic             start;
  logic [7:0]       rows;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_val;
  logic [7:0]       in_col;
  logic             in_ipv;
  logic             issue_valid;
  logic [8*K-1:0]   issue_val;
  logic [8*K-1:0]   issue_col;
  logic [K-1:0]     issue_mask;
  logic [K-1:0]     issue_ipv;
  logic             res_valid;
  logic [K-1:0]     res_ipv;
  logic             busy;
  logic             done;

  modport master (
    output start, rows, in_valid, in_val, in_col, in_ipv,
    input  in_ready, issue_valid, issue_val, issue_col, issue_mask, issue_ipv,
           res_valid, res_ipv, busy, done
  );

  modport slave (
    input  start, rows, in_valid, in_val, in_col, in_ipv,
    output in_ready, issue_valid, issue_val, issue_col, issue_mask, issue_ipv,
           res_valid, res_ipv, busy, done
  );
endinterface

// File: rtl/smvm_issue_ctrl.sv
// smvm_issue_ctrl: packs the serial sparse-matrix element stream into K-lane
// issue groups, counts completed rows, flushes the final partial group and
// delays {issue_valid, issue_ipv} by PIPE_LAT cycles so row-end flags reach
// the accumulators aligned with the L4 results.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : smvm_issue_if.slave (start/rows command, in_* stream, issue_* group,
//          res_* delayed side-band, busy/done status)

// One issue lane: holds the buffered element for this lane and loads the
// lane's issue register when a group goes out.
module smvm_issue_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,       // accepted element targets this lane
  input  logic       issue,    // a group is issued on this edge
  input  logic       take_in,  // this lane is the one being filled right now
  input  logic       occ,      // lane is part of the outgoing group
  input  logic [7:0] in_val,
  input  logic [7:0] in_col,
  input  logic       in_ipv,
  output logic [7:0] o_val,
  output logic [7:0] o_col,
  output logic       o_mask,
  output logic       o_ipv
);
  logic [7:0] b_val, b_col;
  logic       b_ipv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_val  <= '0;
      b_col  <= '0;
      b_ipv  <= 1'b0;
      o_val  <= '0;
      o_col  <= '0;
      o_mask <= 1'b0;
      o_ipv  <= 1'b0;
    end else begin
      if (wr) begin
        b_val <= in_val;
        b_col <= in_col;
        b_ipv <= in_ipv;
      end
      if (issue) begin
        o_mask <= occ;
        // The closing element bypasses the buffer; lanes past it go out as zero.
        if (take_in) begin
          o_val <= in_val;
          o_col <= in_col;
          o_ipv <= in_ipv;
        end else if (occ) begin
          o_val <= b_val;
          o_col <= b_col;
          o_ipv <= b_ipv;
        end else begin
          o_val <= '0;
          o_col <= '0;
          o_ipv <= 1'b0;
        end
      end
    end
  end
endmodule

module smvm_issue_ctrl #(
  parameter int K        = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  smvm_issue_if.slave  bus
);
  localparam int LCW = (K > 1) ? $clog2(K) : 1;
  localparam int DCW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t              state;
  logic [LCW-1:0]      lane_cnt;
  logic [7:0]          rows_q, row_cnt;
  logic [DCW-1:0]      drain_cnt;
  logic                in_ready_q, busy_q, done_q, issue_valid_q;
  logic [PIPE_LAT:1]         vld_pipe;
  logic [PIPE_LAT:1][K-1:0]  ipv_pipe;
  logic [K-1:0][7:0]   lane_val, lane_col;
  logic [K-1:0]        lane_mask, lane_ipv;
  logic                accept, last_row, issue_now;

  assign accept    = in_ready_q & bus.in_valid;
  // rows_q is never 0 while LOAD, so rows_q-1 cannot wrap here.
  assign last_row  = bus.in_ipv && (row_cnt == rows_q - 8'd1);
  assign issue_now = accept && ((lane_cnt == LCW'(K-1)) || last_row);

  // Lane l is placed at packed index K-1-l so lane 0 lands on the MSBs.
  for (genvar l = 0; l < K; l++) begin : g_lane
    smvm_issue_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr      (accept && (lane_cnt == LCW'(l))),
      .issue   (issue_now),
      .take_in (lane_cnt == LCW'(l)),
      .occ     (LCW'(l) <= lane_cnt),
      .in_val  (bus.in_val),
      .in_col  (bus.in_col),
      .in_ipv  (bus.in_ipv),
      .o_val   (lane_val[K-1-l]),
      .o_col   (lane_col[K-1-l]),
      .o_mask  (lane_mask[K-1-l]),
      .o_ipv   (lane_ipv[K-1-l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lane_cnt      <= '0;
      rows_q        <= '0;
      row_cnt       <= '0;
      drain_cnt     <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      issue_valid_q <= 1'b0;
    end else begin
      issue_valid_q <= issue_now;
      done_q        <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          rows_q   <= bus.rows;
          row_cnt  <= '0;
          lane_cnt <= '0;
          busy_q   <= 1'b1;
          if (bus.rows != 8'd0) begin
            state      <= LOAD;
            in_ready_q <= 1'b1;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        LOAD: if (accept) begin
          row_cnt  <= row_cnt + {7'd0, bus.in_ipv};
          lane_cnt <= issue_now ? '0 : lane_cnt + 1'b1;
          if (last_row) begin
            state      <= DRAIN;
            in_ready_q <= 1'b0;
            drain_cnt  <= DCW'(PIPE_LAT);
          end
        end
        // Hold off done until the last group has left the shadow pipe.
        DRAIN: if (drain_cnt == '0) begin
          state  <= DONE;
          done_q <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow pipe: free-running, no stall, mirrors the ALU latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      ipv_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue_valid_q;
      ipv_pipe[1] <= lane_ipv;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ipv_pipe[i] <= ipv_pipe[i-1];
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_val   = lane_val;
  assign bus.issue_col   = lane_col;
  assign bus.issue_mask  = lane_mask;
  assign bus.issue_ipv   = lane_ipv;
  assign bus.res_valid   = vld_pipe[PIPE_LAT];
  assign bus.res_ipv     = ipv_pipe[PIPE_LAT];
endmodule

// File: tb/tb_smvm_issue_ctrl.sv
// tb_smvm_issue_ctrl: table-driven vectors, hand sequences for rows=0, restart
// and mid-pass reset, plus randomized passes checked against a group-level
// reference model (elements chunked by K, flushed at the final row end).
module tb_smvm_issue_ctrl;
  localparam int K        = 4;
  localparam int PIPE_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  smvm_issue_if #(.K(K)) bus ();
  smvm_issue_ctrl #(.K(K), .PIPE_LAT(PIPE_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0] val;
    logic [7:0] col;
    logic       ipv;
  } el_t;

  typedef struct {
    logic [8*K-1:0] val;
    logic [8*K-1:0] col;
    logic [K-1:0]   mask;
    logic [K-1:0]   ipv;
    int             cyc;
  } grp_t;

  typedef struct {
    logic [7:0]  rows;
    int          nel;
    logic [63:0] vals;
    logic [63:0] cols;
    logic [7:0]  ipvs;
    int          gap;
    bit          restart;
    int          ngrp;
    logic [31:0] g0v, g0c;
    logic [3:0]  g0m, g0i;
    logic [31:0] g1v, g1c;
    logic [3:0]  g1m, g1i;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string tag    = "";

  el_t   els_q[$];
  grp_t  exp_g[$];
  grp_t  dut_g[$];
  int    acc_q[$];
  logic [K-1:0] res_ipv_q[$];
  int    res_cyc_q[$];
  int    done_q[$];
  grp_t  mon_g;
  vec_t  tbl[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything sampled mid-cycle, stamped with the edge count.
  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    if (bus.issue_valid) begin
      mon_g.val  = bus.issue_val;
      mon_g.col  = bus.issue_col;
      mon_g.mask = bus.issue_mask;
      mon_g.ipv  = bus.issue_ipv;
      mon_g.cyc  = cyc;
      dut_g.push_back(mon_g);
    end
    if (bus.res_valid) begin
      res_ipv_q.push_back(bus.res_ipv);
      res_cyc_q.push_back(cyc);
    end
    if (bus.done) done_q.push_back(cyc);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, got, exp);
    end
  endtask

  task automatic clear_mon();
    dut_g.delete(); acc_q.delete(); res_ipv_q.delete(); res_cyc_q.delete(); done_q.delete();
  endtask

  // Reference: chunk the stream by K, close early on the row end that
  // completes the pass, pad unused lanes with zero.
  task automatic build_model(input logic [7:0] r);
    el_t  cur[$];
    grp_t g;
    int   rc = 0;
    exp_g.delete();
    for (int i = 0; i < els_q.size(); i++) begin
      cur.push_back(els_q[i]);
      if (els_q[i].ipv) rc++;
      if (cur.size() == K || (els_q[i].ipv && rc == int'(r))) begin
        g = '{default: 0};
        for (int l = 0; l < cur.size(); l++) begin
          g.val[8*(K-1-l) +: 8] = cur[l].val;
          g.col[8*(K-1-l) +: 8] = cur[l].col;
          g.mask[K-1-l]         = 1'b1;
          g.ipv[K-1-l]          = cur[l].ipv;
        end
        exp_g.push_back(g);
        cur.delete();
      end
      if (els_q[i].ipv && rc == int'(r)) break;
    end
  endtask

  task automatic drive_el(input el_t e);
    int w = 0;
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_val   = e.val;
    bus.in_col   = e.col;
    bus.in_ipv   = e.ipv;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = bus.in_ready;
    @(posedge clk); #1;
    chk("accepted", ok, 1);
  endtask

  task automatic run_pass(input logic [7:0] r, input int gap, input bit restart);
    int w = 0;
    clear_mon();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.rows  = r;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < els_q.size(); i++) begin
      if (restart && i == 1) begin
        bus.start = 1'b1;
        bus.rows  = 8'd9;
      end
      drive_el(els_q[i]);
      bus.start = 1'b0;
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    // Keep offering junk past the final element; none of it may be taken.
    bus.in_valid = 1'b1;
    bus.in_val   = 8'h5a;
    bus.in_col   = 8'ha5;
    bus.in_ipv   = 1'b1;
    while (done_q.size() == 0 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_pass();
    int n     = (dut_g.size() < exp_g.size()) ? dut_g.size() : exp_g.size();
    int lanes = 0;
    chk("n_groups", dut_g.size(), exp_g.size());
    for (int g = 0; g < n; g++) begin
      chk($sformatf("g%0d_val", g),  dut_g[g].val,  exp_g[g].val);
      chk($sformatf("g%0d_col", g),  dut_g[g].col,  exp_g[g].col);
      chk($sformatf("g%0d_mask", g), dut_g[g].mask, exp_g[g].mask);
      chk($sformatf("g%0d_ipv", g),  dut_g[g].ipv,  exp_g[g].ipv);
      lanes += $countones(exp_g[g].mask);
      if (lanes - 1 < acc_q.size())
        chk($sformatf("g%0d_issue_lat", g), dut_g[g].cyc, acc_q[lanes-1] + 1);
      if (g < res_cyc_q.size()) begin
        chk($sformatf("g%0d_res_ipv", g), res_ipv_q[g], exp_g[g].ipv);
        chk($sformatf("g%0d_res_lat", g), res_cyc_q[g], dut_g[g].cyc + PIPE_LAT);
      end
    end
    chk("n_accept", acc_q.size(), lanes);
    chk("n_res", res_cyc_q.size(), exp_g.size());
    chk("n_done", done_q.size(), 1);
    if (done_q.size() > 0 && n > 0)
      chk("done_lat", done_q[0], dut_g[n-1].cyc + PIPE_LAT + 1);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    grp_t g;
    int   rc;
    logic [7:0] r;

    tbl[0] = '{8'd1, 4, 64'h0000_0000_02FF_0503, 64'h0000_0000_0907_0200, 8'b0000_1000, 0, 1'b0, 1,
               32'h0305FF02, 32'h00020709, 4'hF, 4'b0001, 32'h0, 32'h0, 4'h0, 4'h0};
    tbl[1] = '{8'd2, 6, 64'h0000_1615_1413_1211, 64'h0000_2625_2423_2221, 8'b0010_0010, 0, 1'b0, 2,
               32'h11121314, 32'h21222324, 4'hF, 4'b0100, 32'h15160000, 32'h25260000, 4'b1100, 4'b0100};
    tbl[2] = '{8'd1, 8, 64'h0807_0605_0403_0201, 64'h1110_0F0E_0D0C_0B0A, 8'b1000_0000, 2, 1'b0, 2,
               32'h01020304, 32'h0A0B0C0D, 4'hF, 4'h0, 32'h05060708, 32'h0E0F1011, 4'hF, 4'b0001};
    tbl[3] = tbl[0];
    tbl[3].restart = 1'b1;

    bus.start = 1'b0; bus.rows = 8'd0; bus.in_valid = 1'b0;
    bus.in_val = 8'd0; bus.in_col = 8'd0; bus.in_ipv = 1'b0;

    // Reset state
    tag = "reset";
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("in_ready", bus.in_ready, 0);
    chk("busy", bus.busy, 0);
    chk("done", bus.done, 0);
    chk("issue_valid", bus.issue_valid, 0);
    chk("issue_mask", bus.issue_mask, 0);
    chk("res_valid", bus.res_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int t = 0; t < 4; t++) begin
      tag = $sformatf("vec%0d", t);
      els_q.delete();
      for (int e = 0; e < tbl[t].nel; e++)
        els_q.push_back({tbl[t].vals[8*e +: 8], tbl[t].cols[8*e +: 8], tbl[t].ipvs[e]});
      exp_g.delete();
      g = '{default: 0};
      g.val = tbl[t].g0v; g.col = tbl[t].g0c; g.mask = tbl[t].g0m; g.ipv = tbl[t].g0i;
      exp_g.push_back(g);
      if (tbl[t].ngrp > 1) begin
        g.val = tbl[t].g1v; g.col = tbl[t].g1c; g.mask = tbl[t].g1m; g.ipv = tbl[t].g1i;
        exp_g.push_back(g);
      end
      run_pass(tbl[t].rows, tbl[t].gap, tbl[t].restart);
      check_pass();
    end

    // rows == 0: straight to DONE, nothing accepted
    tag = "rows0";
    clear_mon();
    bus.in_valid = 1'b1;
    bus.start = 1'b1; bus.rows = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy", bus.busy, 1);
    chk("done", bus.done, 1);
    chk("in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("busy_after", bus.busy, 0);
    chk("done_after", bus.done, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("n_issue", dut_g.size(), 0);
    chk("n_done", done_q.size(), 1);
    chk("n_accept", acc_q.size(), 0);

    // Reset after two accepted elements abandons the pass
    tag = "midrst";
    clear_mon();
    bus.start = 1'b1; bus.rows = 8'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive_el({8'h44, 8'h01, 1'b0});
    drive_el({8'h55, 8'h02, 1'b0});
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("in_ready", bus.in_ready, 0);
    chk("busy", bus.busy, 0);
    chk("issue_val", bus.issue_val, 0);
    chk("issue_col", bus.issue_col, 0);
    chk("issue_mask", bus.issue_mask, 0);
    chk("res_ipv", bus.res_ipv, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done", done_q.size(), 0);
    chk("no_issue", dut_g.size(), 0);
    tag = "after_rst";
    els_q.delete();
    for (int e = 0; e < 4; e++)
      els_q.push_back({tbl[0].vals[8*e +: 8], tbl[0].cols[8*e +: 8], tbl[0].ipvs[e]});
    build_model(8'd1);
    run_pass(8'd1, 0, 1'b0);
    check_pass();

    // rows = 255, one element per row
    tag = "rows255";
    els_q.delete();
    for (int e = 0; e < 255; e++)
      els_q.push_back({8'($urandom), 8'($urandom), 1'b1});
    build_model(8'd255);
    run_pass(8'd255, 0, 1'b0);
    check_pass();

    // Randomized passes
    for (int p = 0; p < 20; p++) begin
      tag = $sformatf("rand%0d", p);
      r = 8'($urandom_range(1, 4));
      rc = 0;
      els_q.delete();
      while (rc < int'(r)) begin
        el_t e;
        e.val = 8'($urandom);
        e.col = 8'($urandom);
        e.ipv = ($urandom_range(0, 2) == 0) || (els_q.size() >= 20);
        if (e.ipv) rc++;
        els_q.push_back(e);
      end
      build_model(r);
      run_pass(r, $urandom_range(0, 2), 1'b0);
      check_pass();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
